// File: rtl/feed_frame_deserializer.sv
// Validates framed 32-bit market-feed beats and releases each good frame's
// messages as 64-bit pulses; bad frames are dropped whole and counted.
module feed_frame_deserializer #(
  parameter int unsigned MAX_MSGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_sop,
  input  logic        s_eop,
  output logic [63:0] raw_market_data,
  output logic        raw_valid,
  output logic        busy,
  output logic [15:0] frame_ok_count,
  output logic [15:0] frame_err_count,
  output logic [15:0] seq_gap_count,
  output logic [15:0] overrun_count
);

  localparam int unsigned AW   = (MAX_MSGS > 1) ? $clog2(MAX_MSGS) : 1;
  localparam logic [7:0]  MaxN = 8'(MAX_MSGS);

  typedef enum logic [2:0] {StIdle, StPayload, StTrailer, StDrain, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d, seq_q, seq_d, exp_seq_q, exp_seq_d;
  logic        seeded_q, seeded_d;
  logic [31:0] csum_q, csum_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  drain_idx_q, drain_idx_d;
  logic        drop_pend_q, drop_pend_d, eop_pend_q, eop_pend_d;
  logic [63:0] raw_data_q, raw_data_d;
  logic        raw_valid_q, raw_valid_d, busy_q, busy_d;
  logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d, ovr_cnt_q, ovr_cnt_d;

  logic [31:0] hi_mem_q [MAX_MSGS];
  logic [31:0] lo_mem_q [MAX_MSGS];

  logic          payload_wr, take_hdr, hdr_ok;
  logic          ok_inc, gap_inc, ovr_inc;
  logic [1:0]    err_inc;
  logic [AW-1:0] wr_slot, rd_slot;
  logic [8:0]    last_idx;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign hdr_ok   = (s_data[31:24] == 8'hA5) && (s_data[15:8] != 8'd0) &&
                    (s_data[15:8] <= MaxN);
  assign wr_slot  = AW'(idx_q[8:1]);
  assign rd_slot  = AW'(drain_idx_q);
  assign last_idx = {n_q, 1'b0} - 9'd1;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    seq_d       = seq_q;
    exp_seq_d   = exp_seq_q;
    seeded_d    = seeded_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    drain_idx_d = drain_idx_q;
    drop_pend_d = drop_pend_q;
    eop_pend_d  = eop_pend_q;
    raw_data_d  = raw_data_q;
    raw_valid_d = 1'b0;
    payload_wr  = 1'b0;
    take_hdr    = 1'b0;
    ok_inc      = 1'b0;
    gap_inc     = 1'b0;
    ovr_inc     = 1'b0;
    err_inc     = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (s_valid && s_sop) take_hdr = 1'b1;
      end
      StPayload: begin
        if (s_valid) begin
          if (s_sop) begin
            err_inc  = err_inc + 2'd1;
            take_hdr = 1'b1;
          end else if (s_eop) begin
            err_inc = err_inc + 2'd1;
            state_d = StIdle;
          end else begin
            payload_wr = 1'b1;
            csum_d     = csum_q ^ s_data;
            idx_d      = idx_q + 9'd1;
            if (idx_q == last_idx) state_d = StTrailer;
          end
        end
      end
      StTrailer: begin
        if (s_valid) begin
          if (s_eop && !s_sop && (s_data == csum_q)) begin
            ok_inc      = 1'b1;
            gap_inc     = seeded_q && (seq_q != exp_seq_q);
            exp_seq_d   = seq_q + 8'd1;
            seeded_d    = 1'b1;
            drain_idx_d = 8'd0;
            state_d     = StDrain;
          end else begin
            err_inc = err_inc + 2'd1;
            if (s_sop) take_hdr = 1'b1;
            else       state_d  = s_eop ? StIdle : StDiscard;
          end
        end
      end
      StDrain: begin
        raw_valid_d = 1'b1;
        raw_data_d  = {hi_mem_q[rd_slot], lo_mem_q[rd_slot]};
        drain_idx_d = drain_idx_q + 8'd1;
        if (s_valid && s_sop) begin
          ovr_inc     = 1'b1;
          drop_pend_d = 1'b1;
          if (!s_eop) eop_pend_d = 1'b1;
        end else if (s_valid && s_eop) begin
          eop_pend_d = 1'b0;
        end
        // A frame still open at drain end must be swallowed up to its eop.
        if (drain_idx_q == n_q - 8'd1) begin
          state_d     = eop_pend_d ? StDiscard : StIdle;
          drop_pend_d = 1'b0;
          eop_pend_d  = 1'b0;
        end
      end
      StDiscard: begin
        if (s_valid && s_eop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (take_hdr) begin
      if (!hdr_ok) begin
        err_inc = err_inc + 2'd1;
        state_d = s_eop ? StIdle : StDiscard;
      end else begin
        n_d     = s_data[15:8];
        seq_d   = s_data[7:0];
        csum_d  = s_data;
        idx_d   = 9'd0;
        state_d = StPayload;
      end
    end

    ok_cnt_d  = sat_add(ok_cnt_q, {1'b0, ok_inc});
    err_cnt_d = sat_add(err_cnt_q, err_inc);
    gap_cnt_d = sat_add(gap_cnt_q, {1'b0, gap_inc});
    ovr_cnt_d = sat_add(ovr_cnt_q, {1'b0, ovr_inc});
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      n_q         <= 8'd0;
      seq_q       <= 8'd0;
      exp_seq_q   <= 8'd0;
      seeded_q    <= 1'b0;
      csum_q      <= 32'd0;
      idx_q       <= 9'd0;
      drain_idx_q <= 8'd0;
      drop_pend_q <= 1'b0;
      eop_pend_q  <= 1'b0;
      raw_data_q  <= 64'd0;
      raw_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ok_cnt_q    <= 16'd0;
      err_cnt_q   <= 16'd0;
      gap_cnt_q   <= 16'd0;
      ovr_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      seq_q       <= seq_d;
      exp_seq_q   <= exp_seq_d;
      seeded_q    <= seeded_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      drain_idx_q <= drain_idx_d;
      drop_pend_q <= drop_pend_d;
      eop_pend_q  <= eop_pend_d;
      raw_data_q  <= raw_data_d;
      raw_valid_q <= raw_valid_d;
      busy_q      <= busy_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  // Message buffer needs no reset: slots are always written before being drained.
  always_ff @(posedge clk) begin
    if (payload_wr && !idx_q[0]) hi_mem_q[wr_slot] <= s_data;
    if (payload_wr &&  idx_q[0]) lo_mem_q[wr_slot] <= s_data;
  end

  assign raw_market_data = raw_data_q;
  assign raw_valid       = raw_valid_q;
  assign busy            = busy_q;
  assign frame_ok_count  = ok_cnt_q;
  assign frame_err_count = err_cnt_q;
  assign seq_gap_count   = gap_cnt_q;
  assign overrun_count   = ovr_cnt_q;

endmodule
